// File: rtl/move_controller.sv
// Othello turn sequencer: cursor, side to move, and the
// detect/write command sequences issued to the board store.
module move_controller #(
  parameter int unsigned DETECT_CYCLES = 10,
  parameter int unsigned WRITE_CYCLES  = 10
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_place,
  input  logic       btn_pass,
  input  logic [1:0] q,
  input  logic [7:0] dir,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       side,
  output logic       detecten,
  output logic       writeen,
  output logic       busy,
  output logic       turn_done,
  output logic       illegal,
  output logic       game_over
);

  localparam int unsigned MAXC =
    (DETECT_CYCLES > WRITE_CYCLES) ?
    DETECT_CYCLES : WRITE_CYCLES;
  localparam int CW = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DLOAD =
    CW'(DETECT_CYCLES - 1);
  localparam logic [CW-1:0] WLOAD =
    CW'(WRITE_CYCLES - 1);
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DETECT,
    S_EVAL,
    S_WRITE,
    S_DONE
  } state_e;

  // Button bit order: place, pass, up, down, left, right
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_PASS  = 4;
  localparam int B_PLACE = 5;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    x_q, x_d;
  logic [2:0]    y_q, y_d;
  logic          side_q, side_d;
  logic [1:0]    pass_q, pass_d;
  logic          gover_q, gover_d;
  logic          det_q, det_d;
  logic          wr_q, wr_d;
  logic          busy_q;
  logic          done_q, done_d;
  logic          ill_q, ill_d;
  logic [5:0]    prev_q;

  logic [5:0] btn_w;
  logic [5:0] ev;
  logic       idle;

  assign btn_w = {btn_place, btn_pass, btn_up,
                  btn_down, btn_left, btn_right};
  assign idle  = (state_q == S_IDLE);
  // Events seen outside IDLE are dropped, never queued
  assign ev    = btn_w & ~prev_q & {6{idle}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    side_d  = side_q;
    pass_d  = pass_q;
    gover_d = gover_q;
    det_d   = 1'b0;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ev[B_PLACE] && !gover_q) begin
          if (q[1]) begin
            ill_d = 1'b1;
          end else begin
            state_d = S_DETECT;
            cnt_d   = DLOAD;
            det_d   = 1'b1;
          end
        end else if (ev[B_PASS] && !gover_q) begin
          side_d = ~side_q;
          if (pass_q != 2'd2)
            pass_d = pass_q + 2'd1;
          if (pass_q == 2'd1)
            gover_d = 1'b1;
        end else begin
          if (ev[B_RIGHT] && !ev[B_LEFT])
            x_d = x_q + 3'd1;
          else if (ev[B_LEFT] && !ev[B_RIGHT])
            x_d = x_q - 3'd1;
          if (ev[B_DOWN] && !ev[B_UP])
            y_d = y_q + 3'd1;
          else if (ev[B_UP] && !ev[B_DOWN])
            y_d = y_q - 3'd1;
        end
      end
      S_DETECT: begin
        if (cnt_q == '0) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q - CONE;
          det_d = 1'b1;
        end
      end
      S_EVAL: begin
        if (|dir) begin
          state_d = S_WRITE;
          cnt_d   = WLOAD;
          wr_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
          ill_d   = 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CONE;
          wr_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        side_d  = ~side_q;
        pass_d  = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      side_q  <= 1'b0;
      pass_q  <= 2'd0;
      gover_q <= 1'b0;
      det_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      prev_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      side_q  <= side_d;
      pass_q  <= pass_d;
      gover_q <= gover_d;
      det_q   <= det_d;
      wr_q    <= wr_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      ill_q   <= ill_d;
      prev_q  <= btn_w;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign side      = side_q;
  assign detecten  = det_q;
  assign writeen   = wr_q;
  assign busy      = busy_q;
  assign turn_done = done_q;
  assign illegal   = ill_q;
  assign game_over = gover_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with a small
// board model driving q and a bench-set dir mask.
module tb_move_controller;

  logic       clock;
  logic       resetn;
  logic [5:0] btn;
  logic [1:0] q;
  logic [7:0] dir;
  logic [2:0] x, y;
  logic       side, detecten, writeen, busy;
  logic       turn_done, illegal, game_over;

  logic [1:0] board [8][8];
  logic [7:0] dir_val;

  int n_cmp;
  int n_bad;

  // btn: 0 right, 1 left, 2 down, 3 up, 4 place, 5 pass
  move_controller dut (
    .clock     (clock),
    .resetn    (resetn),
    .btn_left  (btn[1]),
    .btn_right (btn[0]),
    .btn_up    (btn[3]),
    .btn_down  (btn[2]),
    .btn_place (btn[4]),
    .btn_pass  (btn[5]),
    .q         (q),
    .dir       (dir),
    .x         (x),
    .y         (y),
    .side      (side),
    .detecten  (detecten),
    .writeen   (writeen),
    .busy      (busy),
    .turn_done (turn_done),
    .illegal   (illegal),
    .game_over (game_over)
  );

  assign q   = board[y][x];
  assign dir = dir_val;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      btn[b] = 1'b1;
      tick();
      btn[b] = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    btn    = 6'd0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({x, y} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y);
    end
    n_cmp++;
    if ({side, detecten, writeen, busy} !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 0000",
               {side, detecten, writeen, busy});
    end
    n_cmp++;
    if ({turn_done, illegal, game_over} !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000",
               {turn_done, illegal, game_over});
    end
  endtask

  task automatic test_cursor();
    btn[0] = 1'b1;
    tick();
    n_cmp++;
    if (x !== 3'd1) begin
      n_bad++;
      $display("FAIL cursor_latency: got %0d want 1", x);
    end
    btn[0] = 1'b0;
    tick();
    press(0, 2);
    press(2, 4);
    n_cmp++;
    if (x !== 3'd3 || y !== 3'd4) begin
      n_bad++;
      $display("FAIL cursor_rd: got %0d,%0d want 3,4", x, y);
    end
    press(3, 5);
    n_cmp++;
    if (y !== 3'd7) begin
      n_bad++;
      $display("FAIL cursor_upwrap: got %0d want 7", y);
    end
    press(1, 4);
    n_cmp++;
    if (x !== 3'd7) begin
      n_bad++;
      $display("FAIL cursor_leftwrap: got %0d want 7", x);
    end
    press(0, 1);
    press(2, 1);
    n_cmp++;
    if (x !== 3'd0 || y !== 3'd0) begin
      n_bad++;
      $display("FAIL cursor_fwdwrap: got %0d,%0d want 0,0",
               x, y);
    end
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    btn[2] = 1'b1;
    btn[3] = 1'b1;
    tick();
    btn = 6'd0;
    tick();
    n_cmp++;
    if (x !== 3'd0 || y !== 3'd0) begin
      n_bad++;
      $display("FAIL cursor_both: got %0d,%0d want 0,0", x, y);
    end
  endtask

  task automatic test_legal_move();
    int det_n, det_first, wr_n, wr_first;
    int busy_n, done_at, done_n, both_n, moved_n;
    do_reset();
    press(0, 3);
    press(2, 2);
    dir_val = 8'h04;
    det_n = 0; det_first = 0; wr_n = 0; wr_first = 0;
    busy_n = 0; done_at = 0; done_n = 0;
    both_n = 0; moved_n = 0;
    btn[4] = 1'b1;
    tick();
    btn[4] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (detecten) begin
        det_n++;
        if (det_first == 0) det_first = c;
      end
      if (writeen) begin
        wr_n++;
        if (wr_first == 0) wr_first = c;
      end
      if (busy) busy_n++;
      if (turn_done) begin
        done_n++;
        done_at = c;
      end
      if (detecten && writeen) both_n++;
      if (c <= 22 && (x !== 3'd3 || y !== 3'd2 || side !== 1'b0))
        moved_n++;
      btn[0] = (c == 5);
      tick();
    end
    btn[0] = 1'b0;
    n_cmp++;
    if (det_n != 10 || det_first != 1) begin
      n_bad++;
      $display("FAIL legal_detect: got %0d from %0d want 10 from 1",
               det_n, det_first);
    end
    n_cmp++;
    if (wr_n != 10 || wr_first != 12) begin
      n_bad++;
      $display("FAIL legal_write: got %0d from %0d want 10 from 12",
               wr_n, wr_first);
    end
    n_cmp++;
    if (done_n != 1 || done_at != 22) begin
      n_bad++;
      $display("FAIL legal_done: got %0d at %0d want 1 at 22",
               done_n, done_at);
    end
    n_cmp++;
    if (busy_n != 22) begin
      n_bad++;
      $display("FAIL legal_busy: got %0d want 22", busy_n);
    end
    n_cmp++;
    if (both_n != 0 || moved_n != 0) begin
      n_bad++;
      $display("FAIL legal_frozen: got %0d/%0d want 0/0",
               both_n, moved_n);
    end
    n_cmp++;
    if (side !== 1'b1 || x !== 3'd3) begin
      n_bad++;
      $display("FAIL legal_after: got side %0d x %0d want 1 3",
               side, x);
    end
  endtask

  task automatic test_occupied();
    press(2, 1);
    btn[4] = 1'b1;
    tick();
    btn[4] = 1'b0;
    n_cmp++;
    if (illegal !== 1'b1 || busy !== 1'b0 ||
        detecten !== 1'b0) begin
      n_bad++;
      $display("FAIL occ_pulse: got ill %b busy %b det %b want 1 0 0",
               illegal, busy, detecten);
    end
    tick();
    n_cmp++;
    if (illegal !== 1'b0 || side !== 1'b1 ||
        detecten !== 1'b0) begin
      n_bad++;
      $display("FAIL occ_after: got ill %b side %b det %b want 0 1 0",
               illegal, side, detecten);
    end
  endtask

  task automatic test_dir_zero();
    int det_n, wr_n, ill_at, ill_n;
    press(1, 1);
    press(3, 1);
    dir_val = 8'h00;
    det_n = 0; wr_n = 0; ill_at = 0; ill_n = 0;
    btn[4] = 1'b1;
    tick();
    btn[4] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (detecten) det_n++;
      if (writeen) wr_n++;
      if (illegal) begin
        ill_n++;
        ill_at = c;
      end
      tick();
    end
    n_cmp++;
    if (det_n != 10 || wr_n != 0) begin
      n_bad++;
      $display("FAIL dir0_cmds: got det %0d wr %0d want 10 0",
               det_n, wr_n);
    end
    n_cmp++;
    if (ill_n != 1 || ill_at != 12) begin
      n_bad++;
      $display("FAIL dir0_illegal: got %0d at %0d want 1 at 12",
               ill_n, ill_at);
    end
    n_cmp++;
    if (side !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL dir0_side: got side %b busy %b want 1 0",
               side, busy);
    end
  endtask

  task automatic test_pass_game_over();
    int busy_n;
    do_reset();
    press(5, 1);
    n_cmp++;
    if (side !== 1'b1 || game_over !== 1'b0) begin
      n_bad++;
      $display("FAIL pass1: got side %b go %b want 1 0",
               side, game_over);
    end
    press(5, 1);
    n_cmp++;
    if (side !== 1'b0 || game_over !== 1'b1) begin
      n_bad++;
      $display("FAIL pass2: got side %b go %b want 0 1",
               side, game_over);
    end
    dir_val = 8'h01;
    busy_n = 0;
    btn[4] = 1'b1;
    tick();
    btn[4] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (busy || detecten) busy_n++;
      tick();
    end
    press(5, 1);
    n_cmp++;
    if (busy_n != 0 || side !== 1'b0) begin
      n_bad++;
      $display("FAIL go_ignore: got busy %0d side %b want 0 0",
               busy_n, side);
    end
    press(0, 1);
    n_cmp++;
    if (x !== 3'd1 || game_over !== 1'b1) begin
      n_bad++;
      $display("FAIL go_cursor: got x %0d go %b want 1 1",
               x, game_over);
    end
  endtask

  task automatic test_pass_move_pass();
    do_reset();
    press(5, 1);
    dir_val = 8'h01;
    btn[4] = 1'b1;
    tick();
    btn[4] = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    n_cmp++;
    if (side !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pmp_move: got side %b busy %b want 0 0",
               side, busy);
    end
    press(5, 1);
    n_cmp++;
    if (game_over !== 1'b0 || side !== 1'b1) begin
      n_bad++;
      $display("FAIL pmp_pass: got go %b side %b want 0 1",
               game_over, side);
    end
    press(5, 1);
    n_cmp++;
    if (game_over !== 1'b1) begin
      n_bad++;
      $display("FAIL pmp_second: got go %b want 1", game_over);
    end
  endtask

  task automatic test_reset_mid();
    int wr_n, done_n;
    do_reset();
    press(0, 1);
    press(2, 1);
    dir_val = 8'h10;
    btn[4] = 1'b1;
    tick();
    btn[4] = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    n_cmp++;
    if (writeen !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_write: got %b want 1", writeen);
    end
    resetn = 1'b0;
    tick();
    n_cmp++;
    if (writeen !== 1'b0 || busy !== 1'b0 ||
        x !== 3'd0 || y !== 3'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got wr %b busy %b xy %0d,%0d want 0 0 0,0",
               writeen, busy, x, y);
    end
    resetn = 1'b1;
    wr_n = 0;
    done_n = 0;
    for (int c = 0; c < 15; c++) begin
      if (writeen || detecten) wr_n++;
      if (turn_done || illegal) done_n++;
      tick();
    end
    n_cmp++;
    if (wr_n != 0 || done_n != 0 || side !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_quiet: got cmd %0d pulse %0d side %b want 0 0 0",
               wr_n, done_n, side);
    end
  endtask

  task automatic test_place_and_right();
    int done_n;
    do_reset();
    press(0, 2);
    dir_val = 8'h80;
    btn[4] = 1'b1;
    btn[0] = 1'b1;
    tick();
    btn = 6'd0;
    n_cmp++;
    if (detecten !== 1'b1 || x !== 3'd2) begin
      n_bad++;
      $display("FAIL pr_start: got det %b x %0d want 1 2",
               detecten, x);
    end
    done_n = 0;
    for (int c = 1; c <= 30; c++) begin
      if (turn_done) done_n++;
      tick();
    end
    n_cmp++;
    if (done_n != 1 || x !== 3'd2 || side !== 1'b1) begin
      n_bad++;
      $display("FAIL pr_done: got done %0d x %0d side %b want 1 2 1",
               done_n, x, side);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    btn     = 6'd0;
    resetn  = 1'b0;
    dir_val = 8'h00;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        board[r][c] = 2'd0;
    board[3][3] = 2'd2;
    board[4][4] = 2'd2;
    board[3][4] = 2'd3;
    board[4][3] = 2'd3;
    test_reset();
    test_cursor();
    test_legal_move();
    test_occupied();
    test_dir_zero();
    test_pass_game_over();
    test_pass_move_pass();
    test_reset_mid();
    test_place_and_right();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
